// File: rtl/ifm_pingpong_ctrl_s9_pkg.sv
// Shared sizing and state encodings for the IFM ping-pong sequencers.
// S-size variants pick their own feature-map side and reuse the helpers.
package ifm_pingpong_ctrl_s9_pkg;

  localparam int IFM_SIZE_S9 = 9;
  localparam int NPIX        = IFM_SIZE_S9 * IFM_SIZE_S9;
  localparam int NPAIR       = (NPIX + 1) / 2;

  typedef enum logic {W_FILL = 1'b0, W_FULL = 1'b1} w_state_t;
  typedef enum logic {R_IDLE = 1'b0, R_READ = 1'b1} r_state_t;

  function automatic int npix_of(input int size);
    return size * size;
  endfunction

  function automatic int npair_of(input int size);
    return (size * size + 1) / 2;
  endfunction

endpackage

// File: rtl/ifm_pingpong_ctrl_s9_read_pair_gen.sv
// Read-bank sweeper: issues two pixel addresses per accepted cycle and
// delays valid/last by one cycle to line up with the memory read data.
module ifm_read_pair_gen
  import ifm_pingpong_ctrl_s9_pkg::*;
#(
  parameter int NPIX_P  = NPIX,
  parameter int NPAIR_P = NPAIR,
  parameter int ADDR_W  = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              next_ready,
  output logic              idle,
  output logic              en_a,
  output logic              en_b,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic              next_valid,
  output logic              next_b_valid,
  output logic              next_last
);

  r_state_t          r_state_reg, r_state_next;
  logic [ADDR_W-1:0] pcnt_reg, pcnt_next;
  logic [ADDR_W:0]   addr_b_wide;
  logic              issue, b_ok, is_last;
  logic              valid_reg, b_valid_reg, last_reg;

  assign idle = (r_state_reg == R_IDLE);

  always_comb begin
    r_state_next = r_state_reg;
    pcnt_next    = pcnt_reg;
    // One extra bit so the odd address cannot wrap before the range compare.
    addr_b_wide  = {pcnt_reg, 1'b1};
    issue        = (r_state_reg == R_READ) && next_ready;
    b_ok         = addr_b_wide <= (ADDR_W+1)'(NPIX_P - 1);
    is_last      = pcnt_reg == ADDR_W'(NPAIR_P - 1);
    case (r_state_reg)
      R_IDLE: begin
        if (start) begin
          r_state_next = R_READ;
          pcnt_next    = '0;
        end
      end
      R_READ: begin
        if (issue) begin
          if (is_last) begin
            r_state_next = R_IDLE;
            pcnt_next    = '0;
          end else begin
            pcnt_next = pcnt_reg + 1'b1;
          end
        end
      end
      default: r_state_next = R_IDLE;
    endcase
    en_a   = issue;
    en_b   = issue && b_ok;
    addr_a = issue ? {pcnt_reg[ADDR_W-2:0], 1'b0} : '0;
    addr_b = (issue && b_ok) ? addr_b_wide[ADDR_W-1:0] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state_reg <= R_IDLE;
      pcnt_reg    <= '0;
      valid_reg   <= 1'b0;
      b_valid_reg <= 1'b0;
      last_reg    <= 1'b0;
    end else begin
      r_state_reg <= r_state_next;
      pcnt_reg    <= pcnt_next;
      valid_reg   <= issue;
      b_valid_reg <= issue && b_ok;
      last_reg    <= issue && is_last;
    end
  end

  assign next_valid   = valid_reg;
  assign next_b_valid = b_valid_reg;
  assign next_last    = last_reg;

endmodule

// File: rtl/ifm_pingpong_ctrl_s9.sv
// Ping-pong sequencer for the S9 IFM memory pair: fills one bank from the
// raster stream while the other is swept in pairs, swapping when both finish.
module ifm_pingpong_ctrl_s9
  import ifm_pingpong_ctrl_s9_pkg::*;
#(
  parameter int IFM_SIZE         = IFM_SIZE_S9,
  parameter int ADDRESS_SIZE_IFM = $clog2(IFM_SIZE * IFM_SIZE)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  output logic                        ifm_enable_write_previous,
  output logic [ADDRESS_SIZE_IFM-1:0] ifm_address_write_previous,
  output logic                        ifm_enable_read_previous,
  output logic [ADDRESS_SIZE_IFM-1:0] ifm_address_read_previous,
  input  logic                        next_ready,
  output logic                        ifm_enable_read_A_next,
  output logic                        ifm_enable_read_B_next,
  output logic [ADDRESS_SIZE_IFM-1:0] ifm_address_read_A_next,
  output logic [ADDRESS_SIZE_IFM-1:0] ifm_address_read_B_next,
  output logic                        next_valid,
  output logic                        next_b_valid,
  output logic                        next_last,
  output logic                        ifm_sel
);

  localparam int NPIX_L  = npix_of(IFM_SIZE);
  localparam int NPAIR_L = npair_of(IFM_SIZE);
  localparam logic [ADDRESS_SIZE_IFM-1:0] LAST_PIX = ADDRESS_SIZE_IFM'(NPIX_L - 1);

  w_state_t                    w_state_reg, w_state_next;
  logic [ADDRESS_SIZE_IFM-1:0] wcnt_reg, wcnt_next;
  logic                        ifm_sel_reg, ifm_sel_next;
  logic                        rd_idle, swap, wr_fire;

  always_comb begin
    w_state_next = w_state_reg;
    wcnt_next    = wcnt_reg;
    ifm_sel_next = ifm_sel_reg;
    wr_ready     = 1'b0;
    wr_fire      = 1'b0;
    swap         = 1'b0;
    case (w_state_reg)
      W_FILL: begin
        wr_ready = 1'b1;
        wr_fire  = wr_valid;
        if (wr_valid) begin
          if (wcnt_reg == LAST_PIX) begin
            wcnt_next    = '0;
            w_state_next = W_FULL;
          end else begin
            wcnt_next = wcnt_reg + 1'b1;
          end
        end
      end
      W_FULL: begin
        // Upstream holds its pixel until the reader has drained the other bank.
        if (rd_idle) begin
          swap         = 1'b1;
          w_state_next = W_FILL;
          ifm_sel_next = ~ifm_sel_reg;
        end
      end
      default: w_state_next = W_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state_reg <= W_FILL;
      wcnt_reg    <= '0;
      ifm_sel_reg <= 1'b0;
    end else begin
      w_state_reg <= w_state_next;
      wcnt_reg    <= wcnt_next;
      ifm_sel_reg <= ifm_sel_next;
    end
  end

  // Addresses from both banks are ORed in the array, so idle ports drive zero.
  assign ifm_enable_write_previous  = wr_fire;
  assign ifm_address_write_previous = wr_fire ? wcnt_reg : '0;
  assign ifm_enable_read_previous   = 1'b0;
  assign ifm_address_read_previous  = '0;
  assign ifm_sel                    = ifm_sel_reg;

  ifm_read_pair_gen #(
    .NPIX_P  (NPIX_L),
    .NPAIR_P (NPAIR_L),
    .ADDR_W  (ADDRESS_SIZE_IFM)
  ) u_read_pair_gen (
    .clk          (clk),
    .reset        (reset),
    .start        (swap),
    .next_ready   (next_ready),
    .idle         (rd_idle),
    .en_a         (ifm_enable_read_A_next),
    .en_b         (ifm_enable_read_B_next),
    .addr_a       (ifm_address_read_A_next),
    .addr_b       (ifm_address_read_B_next),
    .next_valid   (next_valid),
    .next_b_valid (next_b_valid),
    .next_last    (next_last)
  );

endmodule

// File: tb/tb_ifm_pingpong_ctrl_s9.sv
// Scoreboard bench for the S9 IFM ping-pong sequencer: a frame-level model
// queues expected writes, read pairs and responses; a monitor pops and compares.
module tb_ifm_pingpong_ctrl_s9;

  localparam int NPIX  = 81;
  localparam int NPAIR = 41;
  localparam int AW    = 7;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_valid = 1'b0;
  logic          next_ready = 1'b0;
  logic          wr_ready;
  logic          ifm_enable_write_previous;
  logic [AW-1:0] ifm_address_write_previous;
  logic          ifm_enable_read_previous;
  logic [AW-1:0] ifm_address_read_previous;
  logic          ifm_enable_read_A_next, ifm_enable_read_B_next;
  logic [AW-1:0] ifm_address_read_A_next, ifm_address_read_B_next;
  logic          next_valid, next_b_valid, next_last, ifm_sel;

  ifm_pingpong_ctrl_s9 dut (
    .clk                        (clk),
    .reset                      (reset),
    .wr_valid                   (wr_valid),
    .wr_ready                   (wr_ready),
    .ifm_enable_write_previous  (ifm_enable_write_previous),
    .ifm_address_write_previous (ifm_address_write_previous),
    .ifm_enable_read_previous   (ifm_enable_read_previous),
    .ifm_address_read_previous  (ifm_address_read_previous),
    .next_ready                 (next_ready),
    .ifm_enable_read_A_next     (ifm_enable_read_A_next),
    .ifm_enable_read_B_next     (ifm_enable_read_B_next),
    .ifm_address_read_A_next    (ifm_address_read_A_next),
    .ifm_address_read_B_next    (ifm_address_read_B_next),
    .next_valid                 (next_valid),
    .next_b_valid               (next_b_valid),
    .next_last                  (next_last),
    .ifm_sel                    (ifm_sel)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic wr_ready; logic sel; logic wr_en; logic a_en; logic b_en; logic nv;
  } status_t;
  typedef struct packed {logic [AW-1:0] a; logic b_en; logic [AW-1:0] b;} rd_t;
  typedef struct packed {int due; logic bv; logic last;} resp_t;

  status_t       st_q[$];
  logic [AW-1:0] wr_q[$];
  rd_t           rd_q[$];
  resp_t         resp_q[$];
  int errors = 0;
  int checks = 0;

  // Frame-level reference: pixels written into the fill bank, pairs read out
  // of the drain bank, and which bank is which.
  int m_written, m_pairs;
  bit m_reading, m_sel, m_prev_issue;

  task automatic model_reset();
    m_written = 0; m_pairs = 0; m_reading = 0; m_sel = 0; m_prev_issue = 0;
    resp_q.delete();
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset = 1'b1; wr_valid = 1'b0; next_ready = 1'b0;
      model_reset();
    end
  endtask

  task automatic step(input bit wv, input bit nr);
    bit full, wfire, swap, issue, bexists, last;
    @(negedge clk);
    reset = 1'b0; wr_valid = wv; next_ready = nr;
    full    = (m_written == NPIX);
    wfire   = !full && wv;
    swap    = full && !m_reading;
    issue   = m_reading && nr;
    bexists = (2 * m_pairs + 1) < NPIX;
    last    = (m_pairs == NPAIR - 1);
    st_q.push_back('{wr_ready: !full, sel: m_sel, wr_en: wfire, a_en: issue,
                     b_en: issue && bexists, nv: m_prev_issue});
    if (wfire) wr_q.push_back(AW'(m_written));
    if (issue) begin
      rd_q.push_back('{a: AW'(2 * m_pairs), b_en: bexists,
                       b: bexists ? AW'(2 * m_pairs + 1) : AW'(0)});
      resp_q.push_back('{due: cyc + 1, bv: bexists, last: last});
    end
    m_prev_issue = issue;
    if (wfire) m_written++;
    if (swap) begin
      m_written = 0; m_sel = !m_sel; m_reading = 1; m_pairs = 0;
    end
    if (issue) begin
      m_pairs++;
      if (m_pairs == NPAIR) m_reading = 0;
    end
  endtask

  // Monitor: samples 1 time unit after the driver's negedge update.
  initial begin
    status_t got, exp;
    logic [AW-1:0] ewa;
    rd_t er, gr;
    resp_t ep;
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        got = '{wr_ready, ifm_sel, ifm_enable_write_previous, ifm_enable_read_A_next,
                ifm_enable_read_B_next, next_valid};
        checks++;
        if (st_q.size() == 0) begin
          errors++;
          $display("FAIL status_q cyc=%0d: no expectation queued", cyc);
        end else begin
          exp = st_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL status cyc=%0d got rdy,sel,we,ea,eb,nv=%b required %b", cyc, got, exp);
          end
        end
        checks++;
        if (ifm_enable_read_previous !== 1'b0 || ifm_address_read_previous !== '0 ||
            (!ifm_enable_write_previous && ifm_address_write_previous !== '0) ||
            (!ifm_enable_read_A_next && ifm_address_read_A_next !== '0) ||
            (!ifm_enable_read_B_next && ifm_address_read_B_next !== '0) ||
            (!next_valid && (next_b_valid !== 1'b0 || next_last !== 1'b0))) begin
          errors++;
          $display("FAIL idle_zero cyc=%0d got rp=%b/%0d wa=%0d A=%0d B=%0d bv=%b last=%b required inactive=0",
                   cyc, ifm_enable_read_previous, ifm_address_read_previous,
                   ifm_address_write_previous, ifm_address_read_A_next,
                   ifm_address_read_B_next, next_b_valid, next_last);
        end
        if (ifm_enable_write_previous === 1'b1) begin
          checks++;
          if (wr_q.size() == 0) begin
            errors++;
            $display("FAIL write cyc=%0d got addr=%0d required no write", cyc, ifm_address_write_previous);
          end else begin
            ewa = wr_q.pop_front();
            if (ifm_address_write_previous !== ewa) begin
              errors++;
              $display("FAIL write_addr cyc=%0d got %0d required %0d", cyc, ifm_address_write_previous, ewa);
            end else
              $display("cyc=%0d write addr=%0d sel=%b", cyc, ewa, ifm_sel);
          end
        end
        if (ifm_enable_read_A_next === 1'b1) begin
          checks++;
          gr = '{ifm_address_read_A_next, ifm_enable_read_B_next, ifm_address_read_B_next};
          if (rd_q.size() == 0) begin
            errors++;
            $display("FAIL read cyc=%0d got A=%0d required no read", cyc, ifm_address_read_A_next);
          end else begin
            er = rd_q.pop_front();
            if (gr !== er) begin
              errors++;
              $display("FAIL read_pair cyc=%0d got A=%0d eb=%b B=%0d required A=%0d eb=%b B=%0d",
                       cyc, gr.a, gr.b_en, gr.b, er.a, er.b_en, er.b);
            end
          end
        end
        if (next_valid === 1'b1) begin
          checks++;
          if (resp_q.size() == 0) begin
            errors++;
            $display("FAIL resp cyc=%0d got next_valid required none", cyc);
          end else begin
            ep = resp_q.pop_front();
            if (ep.due != cyc || next_b_valid !== ep.bv || next_last !== ep.last) begin
              errors++;
              $display("FAIL resp cyc=%0d got bv=%b last=%b required cyc=%0d bv=%b last=%b",
                       cyc, next_b_valid, next_last, ep.due, ep.bv, ep.last);
            end else
              $display("cyc=%0d pair valid b_valid=%b last=%b", cyc, next_b_valid, next_last);
          end
        end
      end
    end
  end

  initial begin
    model_reset();
    do_reset(2);
    // Straight fill of the first frame, swap, first writes of the next.
    repeat (83) step(1'b1, 1'b0);
    // Downstream accepts every third cycle: writer must stall in full.
    for (int i = 0; i < 150; i++) step(1'b1, (i % 3) == 0);
    repeat (600) step(1'($urandom_range(0, 1)), 1'b1);
    repeat (500) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    // Reset with the reader at pair 20 and the writer at pixel 37.
    do_reset(1);
    repeat (82) step(1'b1, 1'b0);
    repeat (20) step(1'b1, 1'b1);
    repeat (17) step(1'b1, 1'b0);
    do_reset(1);
    repeat (120) step(1'($urandom_range(0, 1)), 1'b0);
    repeat (300) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    repeat (100) step(1'b0, 1'b1);
    #3;
    checks++;
    if (wr_q.size() != 0 || rd_q.size() != 0 || resp_q.size() != 0 || st_q.size() != 0) begin
      errors++;
      $display("FAIL drain got pending wr=%0d rd=%0d resp=%0d st=%0d required all 0",
               wr_q.size(), rd_q.size(), resp_q.size(), st_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
